// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: E-stage forwarding, load-use stall, mispredict/redirect
// flushes, and a three-state data-cache miss refill sequencer with req/ack handshake.
module pipeline_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic [1:0]       ResultSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MispredictE,
  input  logic             pc_predict_redirect_D,
  input  logic             MemAccessM,
  input  logic             CacheHitM,
  input  logic             mem_ack,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_req,
  output logic             miss_busy,
  output logic [CNT_W-1:0] miss_stall_cycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    REPLAY = 2'd2
  } miss_state_t;

  miss_state_t      r_state;
  logic             r_mem_req;
  logic             r_miss_busy;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_miss_lookup;
  logic w_ms;
  logic w_lu;
  logic w_lu_eff;
  logic w_mispredict_eff;
  logic w_redirect_eff;

  // M-stage result takes priority over W since it is the younger write.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  always_comb begin
    w_miss_lookup = (r_state == IDLE) && MemAccessM && !CacheHitM;
    w_ms          = w_miss_lookup || (r_state != IDLE);
    w_lu          = (ResultSrcE == 2'b01) && RegWriteE && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // A miss stall freezes everything and masks the other hazards; they
  // re-evaluate on the first released cycle. A mispredict kills the F/D
  // instructions, so a coincident load-use stall is pointless.
  always_comb begin
    w_mispredict_eff = MispredictE && !w_ms;
    w_lu_eff         = w_lu && !MispredictE && !w_ms;
    w_redirect_eff   = pc_predict_redirect_D && !w_lu && !MispredictE && !w_ms;

    StallF = w_ms || w_lu_eff;
    StallD = w_ms || w_lu_eff;
    StallE = w_ms;
    StallM = w_ms;
    FlushD = w_mispredict_eff || w_redirect_eff;
    FlushE = w_mispredict_eff || (w_lu && !w_ms);
    FlushW = w_ms;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_miss_busy <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_ms)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          if (w_miss_lookup) begin
            r_state     <= REFILL;
            r_mem_req   <= 1'b1;
            r_miss_busy <= 1'b1;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            r_state   <= REPLAY;
            r_mem_req <= 1'b0;
          end
        end
        REPLAY: begin
          r_state     <= IDLE;
          r_mem_req   <= 1'b0;
          r_miss_busy <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_mem_req   <= 1'b0;
          r_miss_busy <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req           = r_mem_req;
  assign miss_busy         = r_miss_busy;
  assign miss_stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: table-driven combinational vectors plus
// hand-written miss/reset sequences, all checked through an expectation queue.
module tb_pipeline_ctrl;
  localparam int unsigned CNT_W = 32;
  localparam logic [6:0] MS = 7'b1111001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic RegWriteE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
  logic [1:0] ResultSrcE = '0;
  logic MispredictE = 1'b0, pc_predict_redirect_D = 1'b0;
  logic MemAccessM = 1'b0, CacheHitM = 1'b0, mem_ack = 1'b0;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_req, miss_busy;
  logic [CNT_W-1:0] miss_stall_cycles;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MispredictE(MispredictE), .pc_predict_redirect_D(pc_predict_redirect_D),
    .MemAccessM(MemAccessM), .CacheHitM(CacheHitM), .mem_ack(mem_ack),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .mem_req(mem_req), .miss_busy(miss_busy), .miss_stall_cycles(miss_stall_cycles)
  );

  // ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwe, rwm, rww;
    logic [1:0] rse;
    logic       misp, redir;
    logic [1:0] fa, fb;
    logic [6:0] ctl;
  } vec_t;

  typedef struct {
    string            name;
    logic [1:0]       fa, fb;
    logic [6:0]       ctl;
    logic             req, busy;
    bit               cnt_chk;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void push(string nm, logic [1:0] fa, logic [1:0] fb, logic [6:0] ctl,
                               logic req, logic busy, bit cc, logic [CNT_W-1:0] cnt);
    exp_t e;
    e.name = nm; e.fa = fa; e.fb = fb; e.ctl = ctl;
    e.req = req; e.busy = busy; e.cnt_chk = cc; e.cnt = cnt;
    sbq.push_back(e);
  endfunction

  task automatic check_head();
    exp_t e;
    logic [12:0] act, exp;
    n_tests++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e   = sbq.pop_front();
    act = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           mem_req, miss_busy};
    exp = {e.fa, e.fb, e.ctl, e.req, e.busy};
    if (act !== exp || (e.cnt_chk && miss_stall_cycles !== e.cnt)) begin
      n_fail++;
      $display("FAIL %s: got fa_fb_ctl_req_busy=%b cnt=%0d, required %b cnt=%0d",
               e.name, act, miss_stall_cycles, exp, e.cnt_chk ? e.cnt : miss_stall_cycles);
    end
  endtask

  task automatic step(string nm, logic [6:0] ctl, logic req, logic busy, bit cc,
                      logic [CNT_W-1:0] cnt);
    push(nm, 2'b00, 2'b00, ctl, req, busy, cc, cnt);
    #2;
    check_head();
  endtask

  vec_t vt[17];

  initial begin
    //           rs1d rs2d rs1e rs2e rde rdm rdw rwe rwm rww rse misp redir fa     fb     ctl
    vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vt[1]  = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 2'b00, 0, 0, 2'b10, 2'b00, 7'b0000000};
    vt[2]  = '{0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 2'b00, 0, 0, 2'b01, 2'b00, 7'b0000000};
    vt[3]  = '{0, 0, 5, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vt[4]  = '{0, 0, 3, 9, 0, 3, 9, 0, 1, 1, 2'b00, 0, 0, 2'b10, 2'b01, 7'b0000000};
    vt[5]  = '{0, 0, 0, 9, 0, 9, 9, 0, 1, 1, 2'b00, 0, 0, 2'b00, 2'b10, 7'b0000000};
    vt[6]  = '{0, 0, 0, 9, 0, 9, 9, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vt[7]  = '{0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 7'b1100010};
    vt[8]  = '{0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 2'b01, 1, 0, 2'b00, 2'b00, 7'b0000110};
    vt[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 2'b00, 7'b0000100};
    vt[10] = '{7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 2'b01, 0, 1, 2'b00, 2'b00, 7'b1100010};
    vt[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vt[12] = '{7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vt[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 2'b00, 2'b00, 7'b0000110};
    vt[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 2'b00, 2'b00, 7'b0000110};
    vt[15] = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vt[16] = '{7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00, 7'b0000000};

    // Reset state
    #2;
    step("reset_state", 7'b0000000, 1'b0, 1'b0, 1'b1, '0);
    #10 rst_n = 1'b1;

    // Combinational vectors, FSM idle
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      Rs1D = vt[i].rs1d; Rs2D = vt[i].rs2d; Rs1E = vt[i].rs1e; Rs2E = vt[i].rs2e;
      RdE = vt[i].rde; RdM = vt[i].rdm; RdW = vt[i].rdw;
      RegWriteE = vt[i].rwe; RegWriteM = vt[i].rwm; RegWriteW = vt[i].rww;
      ResultSrcE = vt[i].rse; MispredictE = vt[i].misp; pc_predict_redirect_D = vt[i].redir;
      push($sformatf("vec%0d", i), vt[i].fa, vt[i].fb, vt[i].ctl, 1'b0, 1'b0, 1'b1, '0);
      #2;
      check_head();
    end
    @(negedge clk);
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = '0;
    MispredictE = 0; pc_predict_redirect_D = 0;

    // Miss with ack on the fourth REFILL cycle
    @(negedge clk); MemAccessM = 1; CacheHitM = 0;
    step("miss_detect", MS, 1'b0, 1'b0, 1'b1, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); mem_ack = (i == 4);
      step($sformatf("miss_refill%0d", i), MS, 1'b1, 1'b1, 1'b0, '0);
    end
    @(negedge clk); mem_ack = 0; CacheHitM = 1;
    step("miss_replay", MS, 1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    step("miss_release", 7'b0000000, 1'b0, 1'b0, 1'b1, 32'd6);

    // Miss coinciding with a mispredict, immediate ack
    @(negedge clk); MispredictE = 1; CacheHitM = 0;
    step("misp_miss_detect", MS, 1'b0, 1'b0, 1'b1, 32'd6);
    @(negedge clk); mem_ack = 1; CacheHitM = 1;
    step("misp_miss_refill", MS, 1'b1, 1'b1, 1'b0, '0);
    @(negedge clk); mem_ack = 0;
    step("misp_miss_replay", MS, 1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    step("misp_release", 7'b0000110, 1'b0, 1'b0, 1'b1, 32'd9);
    @(negedge clk); MispredictE = 0; MemAccessM = 0;

    // Async reset mid-refill, then a late ack
    @(negedge clk); MemAccessM = 1; CacheHitM = 0;
    step("rst_miss_detect", MS, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk); MemAccessM = 0;
    step("rst_refill", MS, 1'b1, 1'b1, 1'b0, '0);
    #1 rst_n = 0;
    step("rst_mid_refill", 7'b0000000, 1'b0, 1'b0, 1'b1, '0);
    @(negedge clk); rst_n = 1; mem_ack = 1;
    step("late_ack", 7'b0000000, 1'b0, 1'b0, 1'b1, '0);
    @(negedge clk); mem_ack = 0;
    step("after_late_ack", 7'b0000000, 1'b0, 1'b0, 1'b1, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no completion, required finish within 20000 time units");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and stall controller for the five-stage cached RISC-V core. It generates E-stage forwarding selects, load-use stalls, and branch/jump flushes from the E-stage mispredict and the D-stage predicted redirect. It also sequences data-cache miss refills through a three-state FSM with a req/ack handshake to the memory side. It sits beside the pipeline registers and drives all of their stall and flush enables.

## Interface
Parameters:
- CNT_W, default 32: width of the miss-stall cycle counter.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5  source registers in Decode
- Rs1E, Rs2E, RdE  in  5  sources and destination in Execute
- RegWriteE  in  1  E-stage instruction writes rd
- ResultSrcE  in  2  E-stage result select; 2'b01 marks a load
- RdM, RdW  in  5  destinations in Memory and Writeback
- RegWriteM, RegWriteW  in  1  M/W write enables
- MispredictE  in  1  E-stage branch/jump resolved against the fetched path
- pc_predict_redirect_D  in  1  D-stage predicted-taken redirect
- MemAccessM  in  1  load or store in Memory
- CacheHitM  in  1  data-cache lookup hit for the M access
- mem_ack  in  1  one-cycle pulse: refill line written
- ForwardAE, ForwardBE  out  2  00 register file, 10 from M, 01 from W
- StallF, StallD, StallE, StallM  out  1  hold pipeline register
- FlushD, FlushE, FlushW  out  1  clear pipeline register to bubble
- mem_req  out  1  refill request, registered
- miss_busy  out  1  FSM not in IDLE
- miss_stall_cycles  out  CNT_W  count of cycles with miss stall asserted

## Operation
- Forwarding (combinational, per operand): select 10 if RegWriteM, RdM != 0 and RdM == Rs1E (Rs2E for B). Otherwise select 01 if the same test holds on W. Otherwise 00. M has priority over W.
- Load-use (lu): ResultSrcE == 01, RegWriteE, RdE != 0, and RdE equals Rs1D or Rs2D.
  - Result: StallF = StallD = 1, FlushE = 1.
- Mispredict: MispredictE results in FlushD = FlushE = 1.
  - It overrides lu: StallF/StallD are 0, because the instructions in F/D are on the wrong path.
- Redirect: pc_predict_redirect_D results in FlushD = 1.
  - It is suppressed when lu or MispredictE is active. It re-fires naturally once D advances.
- Miss stall (ms): ms = (state == IDLE and MemAccessM and !CacheHitM) or state is REFILL or REPLAY.
  - ms results in StallF = StallD = StallE = StallM = 1 and FlushW = 1.
  - ms forces FlushD = FlushE = 0. lu, mispredict and redirect are masked and re-evaluate after release.
- FSM:
  - IDLE: a miss goes to REFILL.
  - REFILL: mem_req = 1. On mem_ack, go to REPLAY.
  - REPLAY: one cycle with stall held while the cache writes the line, then unconditionally IDLE. IDLE re-checks the lookup, and a repeated miss re-enters REFILL.
- mem_req is 1 exactly when state == REFILL. It is held high until mem_ack.
- mem_ack outside REFILL is ignored.
- miss_stall_cycles increments on every cycle ms = 1 and wraps at 2^CNT_W.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and state, with no added latency.
- Miss detection cycle: stall asserts in the same cycle as the missing lookup. The FSM enters REFILL at the next edge, and mem_req rises then.
- mem_ack in cycle t: REPLAY at t+1, IDLE at t+2. The first non-stalled cycle is t+2 if the lookup hits.
- Minimum miss penalty: miss cycle + 1 REFILL cycle (ack immediate) + REPLAY = 3 stall cycles.
- Reset (async, rst_n = 0): state IDLE, mem_req = 0, miss_busy = 0, miss_stall_cycles = 0. Combinational outputs follow their inputs from IDLE.
- Reset asserted mid-refill abandons the request. mem_req drops immediately, and a late mem_ack after reset is ignored.
- Simultaneous mem_ack and a new miss input while in REFILL: go to REPLAY. The new miss is evaluated in IDLE.

## Test plan
- Forwarding: RdM = RdW = 5, RegWriteM = RegWriteW = 1, Rs1E = 5 -> ForwardAE = 10. Same with RegWriteM = 0 -> 01. Same with RdM = RdW = 0 -> 00.
- Load-use: ResultSrcE = 01, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for one cycle. Adding MispredictE = 1 -> StallF = StallD = 0, FlushD = FlushE = 1.
- Redirect: pc_predict_redirect_D = 1 alone -> FlushD = 1, FlushE = 0. With lu active -> FlushD = 0.
- Miss, ack after 4 cycles: all four stalls and FlushW high for 6 cycles. mem_req high for exactly 4 cycles. miss_stall_cycles = 6 afterward.
- Miss during MispredictE: FlushD = FlushE = 0 while stalled. Flushes assert on the first unstalled cycle.
- rst_n low during REFILL: mem_req and miss_busy go to 0 without a clock edge. A subsequent mem_ack causes no state change.
